// File: rtl/regram_cmd_responder.sv
// regram_cmd_responder: RAM/register block-transfer command responder.
// Owns a 2**ADDR_W x DATA_W data RAM and four VEC_N x DATA_W vector registers.
// Moves words between RAM, registers and a VEC_N-word I/O vector behind a
// valid/ready handshake, and ends every command with a one-cycle done pulse.
// Arithmetic ops are rejected with err.
// Optional build macro REGRAM_WIDE_XFER_EN: moves two words per XFER cycle.
module regram_cmd_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int VEC_N  = 16,
  localparam int CNT_W = $clog2(VEC_N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              op,
  input  logic [ADDR_W-1:0]       ram_addr,
  input  logic [CNT_W-1:0]        ram_cnt,
  input  logic [1:0]              reg_sel,
  input  logic [VEC_N*DATA_W-1:0] in_data,
  output logic [VEC_N*DATA_W-1:0] out_data,
  output logic                    done,
  output logic                    err
);

  localparam int IDX_W = CNT_W + 1;
`ifdef REGRAM_WIDE_XFER_EN
  localparam logic [IDX_W-1:0] STEP = IDX_W'(2);
`else
  localparam logic [IDX_W-1:0] STEP = IDX_W'(1);
`endif

  typedef enum logic [2:0] {
    OP_RAM2REG = 3'b000,
    OP_REG2RAM = 3'b001,
    OP_ADDI    = 3'b010,
    OP_MULT    = 3'b011,
    OP_RAM2OUT = 3'b100,
    OP_OUT2RAM = 3'b101,
    OP_RSV6    = 3'b110,
    OP_RSV7    = 3'b111
  } op_t;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        sel_q;
  logic [IDX_W-1:0]  idx;

  logic [DATA_W-1:0] ram      [2**ADDR_W];
  logic [DATA_W-1:0] regs     [4][VEC_N];
  logic [DATA_W-1:0] in_lat   [VEC_N];
  logic [DATA_W-1:0] out_words[VEC_N];

  logic              accept;
  logic [ADDR_W-1:0] a0, a1;
  logic [CNT_W-1:0]  w0, w1;
  logic              second_ok, last;
  logic [DATA_W-1:0] rd0, rd1, src0, src1;

  assign accept = (state == S_IDLE) && cmd_valid;

  // Address/word-slot decode for the current XFER beat.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a0        = addr_q + ADDR_W'(idx);
    a1        = a0 + ADDR_W'(1);
    w0        = idx[CNT_W-1:0];
    w1        = w0 + CNT_W'(1);
`ifdef REGRAM_WIDE_XFER_EN
    second_ok = idx < IDX_W'(cnt_q);
`else
    second_ok = 1'b0;
`endif
    last      = (idx + STEP) > IDX_W'(cnt_q);
    rd0       = ram[a0];
    rd1       = ram[a1];
    src0      = (op_q == OP_REG2RAM) ? regs[sel_q][w0] : in_lat[w0];
    src1      = (op_q == OP_REG2RAM) ? regs[sel_q][w1] : in_lat[w1];
  end

  // Control FSM: accept, step through words, one-cycle DONE with done/err.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_RAM2REG;
      addr_q    <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx       <= '0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (accept) begin
            op_q      <= op_t'(op);
            addr_q    <= ram_addr;
            cnt_q     <= ram_cnt;
            sel_q     <= reg_sel;
            idx       <= '0;
            cmd_ready <= 1'b0;
            case (op_t'(op))
              OP_RAM2REG, OP_REG2RAM, OP_RAM2OUT, OP_OUT2RAM: state <= S_XFER;
              default: begin
                state <= S_DONE;
                done  <= 1'b1;
                err   <= 1'b1;
              end
            endcase
          end
        end
        S_XFER: begin
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + STEP;
          end
        end
        default: begin
          state     <= S_IDLE;
          idx       <= '0;
          done      <= 1'b0;
          err       <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  // Data RAM writes for RegToRam / OutToRam.
  // NOTE: the RAM has no reset; its contents survive rst and it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (state == S_XFER && (op_q == OP_REG2RAM || op_q == OP_OUT2RAM)) begin
      ram[a0] <= src0;
      if (second_ok) ram[a1] <= src1;
    end
  end

  // Capture the OutToRam payload at accept so in_data need only be valid then.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < VEC_N; k++) in_lat[k] <= in_data[k*DATA_W +: DATA_W];
    end
  end

  // Vector registers: loaded by RamToReg, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < VEC_N; k++) regs[r][k] <= '0;
    end else if (state == S_XFER && op_q == OP_RAM2REG) begin
      regs[sel_q][w0] <= rd0;
      if (second_ok) regs[sel_q][w1] <= rd1;
    end
  end

  // Output vector: cleared on RamToOut accept, filled word by word, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < VEC_N; k++) out_words[k] <= '0;
    end else if (accept && op_t'(op) == OP_RAM2OUT) begin
      for (int k = 0; k < VEC_N; k++) out_words[k] <= '0;
    end else if (state == S_XFER && op_q == OP_RAM2OUT) begin
      out_words[w0] <= rd0;
      if (second_ok) out_words[w1] <= rd1;
    end
  end

  // Pack the output words onto the flat port.
  always_comb begin
    out_data = '0;
    for (int k = 0; k < VEC_N; k++) out_data[k*DATA_W +: DATA_W] = out_words[k];
  end

endmodule
